// File: rtl/qam_fifo_reader_if.sv
// FIFO read port plus ready/valid output stream of the QAM FIFO reader.
// The master modport is the reader's view; slave is the FIFO/sink side.
interface qam_fifo_reader_if #(
  parameter int unsigned DATA_W = 10
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_read_data;
  logic              fifo_read_enable;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    input  out_ready,
    output fifo_read_enable,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    output out_ready,
    input  fifo_read_enable,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/qam_fifo_reader.sv
// Pulls words from a synchronous FIFO (one-cycle read latency) into a 2-entry
// skid buffer and presents them on a registered ready/valid stream.
module qam_fifo_reader #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  qam_fifo_reader_if.master   bus,
  output logic                busy,
  output logic [CNT_W-1:0]    word_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                       state_q, state_d;
  logic                         inflight_q, inflight_d;
  logic [1:0]                   occ_q, occ_d;
  logic [1:0][DATA_W-1:0]       buf_q, buf_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         rd_en;
  logic                         capture;
  logic                         xfer;

  // Occupancy plus the outstanding read bounds the buffer at two entries.
  always_comb begin
    rd_en   = (state_q == StRun) && !bus.fifo_empty &&
              (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
    capture = inflight_q;
    xfer    = (occ_q != 2'd0) && bus.out_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pop first, then append the captured word behind whatever remains.
  always_comb begin
    buf_d      = buf_q;
    occ_d      = occ_q;
    inflight_d = rd_en;
    count_d    = count_q;
    if (xfer) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
      count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (capture) begin
      if (occ_d == 2'd0) begin
        buf_d[0] = bus.fifo_read_data;
      end else begin
        buf_d[1] = bus.fifo_read_data;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    bus.fifo_read_enable = rd_en;
    bus.out_valid        = (occ_q != 2'd0);
    bus.out_data         = buf_q[0];
    busy                 = (state_q != StIdle);
    word_count           = count_q;
  end

endmodule

// File: tb/tb_qam_fifo_reader.sv
// Directed bench for qam_fifo_reader: queue-based FIFO/stream model with a
// per-cycle checker plus hand-computed expectations for each scenario.
module tb_qam_fifo_reader;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  qam_fifo_reader_if #(.DATA_W(DATA_W)) bus ();

  qam_fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] rd_log[256];
  int                n_read = 0;
  int                rd_cnt = 0;
  logic [DATA_W-1:0] dlv[256];
  int                n_dlv = 0;
  int                n_out = 0;
  logic [CNT_W-1:0]  exp_cnt = '0;
  logic              hold = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words leave in the order the FIFO handed them out, at most two
  // words are owed downstream, and the count tracks transfers modulo 2^CNT_W.
  always @(negedge clk) begin
    if (rst) begin
      n_out   = n_read + (bus.fifo_read_enable ? 1 : 0);
      exp_cnt = '0;
      hold    = 1'b0;
    end else begin
      chk("word_count", int'(word_count), int'(exp_cnt));
      if (bus.fifo_read_enable) begin
        chk("read_while_empty", int'(bus.fifo_empty), 0);
        chk("read_overflow", int'((n_read - n_out) < 2), 1);
        chk("read_not_busy", int'(busy), 1);
      end
      if (hold) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_data", int'(bus.out_data), int'(hold_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_unread", int'(n_out < n_read), 1);
        if (n_out < n_read) chk("out_order", int'(bus.out_data), int'(rd_log[n_out]));
        dlv[n_dlv] = bus.out_data;
        n_dlv++;
        n_out++;
        exp_cnt = exp_cnt + 1'b1;
      end
      hold      = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
    end
  end

  // One clock of the FIFO model: a read sampled before the edge returns data
  // during the following cycle.
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = bus.fifo_read_enable;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      bus.fifo_read_data = fifo_q.pop_front();
      rd_log[n_read] = bus.fifo_read_data;
      n_read++;
      rd_cnt++;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic wait_dlv(input int target, input int budget, input string name);
    int k = 0;
    while (n_dlv < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, int'(n_dlv >= target), 1);
  endtask

  initial begin
    int base;
    rst                = 1'b1;
    enable             = 1'b0;
    bus.out_ready      = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_read_data = '0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_rden", int'(bus.fifo_read_enable), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_count", int'(word_count), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    // Enable with an empty FIFO: RUN but nothing to read.
    enable = 1'b1;
    tick();
    chk("run_busy", int'(busy), 1);
    chk("run_empty_rden", int'(bus.fifo_read_enable), 0);
    chk("run_empty_valid", int'(bus.out_valid), 0);

    // Three words streamed with ready held high.
    bus.out_ready = 1'b1;
    push(10'h155);
    push(10'h2AA);
    push(10'h3FF);
    wait_dlv(3, 30, "stream3_timeout");
    chk("stream_w0", int'(dlv[0]), 'h155);
    chk("stream_w1", int'(dlv[1]), 'h2AA);
    chk("stream_w2", int'(dlv[2]), 'h3FF);
    chk("stream_count", int'(word_count), 3);

    // Backpressure: buffer fills with exactly two reads and holds.
    bus.out_ready = 1'b0;
    rd_cnt = 0;
    push(10'h011);
    push(10'h022);
    push(10'h033);
    push(10'h044);
    repeat (10) tick();
    chk("bp_reads", rd_cnt, 2);
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_data", int'(bus.out_data), 'h011);
    bus.out_ready = 1'b1;
    wait_dlv(5, 20, "bp_release_timeout");
    chk("bp_w0", int'(dlv[3]), 'h011);
    chk("bp_w1", int'(dlv[4]), 'h022);
    wait_dlv(7, 20, "bp_drain_timeout");
    chk("bp_count", int'(word_count), 7);

    // Enable drops in the cycle a read issues: that word still comes out.
    rd_cnt = 0;
    push(10'h0AB);
    push(10'h0CD);
    enable = 1'b0;
    tick();
    chk("drain_reads_first", rd_cnt, 1);
    chk("drain_busy", int'(busy), 1);
    chk("drain_rden", int'(bus.fifo_read_enable), 0);
    repeat (5) tick();
    chk("drain_reads_total", rd_cnt, 1);
    chk("drain_idle", int'(busy), 0);
    chk("drain_ndlv", n_dlv, 8);
    chk("drain_word", int'(dlv[7]), 'h0AB);
    chk("drain_count", int'(word_count), 8);

    // Reset with two words buffered discards them.
    bus.out_ready = 1'b0;
    enable = 1'b1;
    push(10'h101);
    push(10'h102);
    repeat (5) tick();
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    chk("pre_rst_data", int'(bus.out_data), 'h0CD);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_count", int'(word_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    base = n_dlv;
    wait_dlv(base + 1, 20, "post_rst_timeout");
    chk("post_rst_word", int'(dlv[base]), 'h102);
    chk("post_rst_count", int'(word_count), 1);

    // Counter wrap at 2^CNT_W.
    base = n_dlv;
    for (int i = 0; i < 14; i++) push(DATA_W'(10'h200 + i));
    wait_dlv(base + 14, 60, "wrap_fill_timeout");
    chk("wrap_pre", int'(word_count), 15);
    push(10'h3C3);
    wait_dlv(base + 15, 20, "wrap_timeout");
    chk("wrap_zero", int'(word_count), 0);
    chk("wrap_word", int'(dlv[base + 14]), 'h3C3);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
